// File: rtl/serial_xnor_comparator_if.sv
// rtl/serial_xnor_comparator_if.sv - bit-pair stream and frame result bundle for serial_xnor_comparator
interface serial_xnor_comparator_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          start;
  logic          in_valid;
  logic          x;
  logic          y;
  logic          busy;
  logic          done;
  logic          match;
  logic [CW-1:0] diff_count;
  logic [CW-1:0] first_diff;
  logic [CW-1:0] bit_idx;

  modport master (
    output start, in_valid, x, y,
    input  busy, done, match, diff_count, first_diff, bit_idx
  );

  modport slave (
    input  start, in_valid, x, y,
    output busy, done, match, diff_count, first_diff, bit_idx
  );
endinterface

// File: rtl/serial_xnor_comparator.sv
// rtl/serial_xnor_comparator.sv - serial equality checker accumulating ~(x^y) over a WIDTH-bit frame
module serial_xnor_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_xnor_comparator_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);

  // One-hot so busy and done come straight off state flops.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    state_vec;
  logic          load;
  logic          accept;
  logic          eq;
  logic          match_q;
  logic [CW-1:0] diff_q;
  logic [CW-1:0] first_q;
  logic [CW-1:0] idx_q;

  assign eq        = ~(bus.x ^ bus.y);
  assign state_vec = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results persist through IDLE until the next accepted start reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      diff_q  <= '0;
      first_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      match_q <= 1'b1;
      diff_q  <= '0;
      first_q <= FRAME_LEN;
      idx_q   <= '0;
    end else if (accept) begin
      match_q <= match_q & eq;
      diff_q  <= diff_q + CW'(~eq);
      if (!eq && first_q == FRAME_LEN) begin
        first_q <= idx_q;
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  assign bus.busy       = state_vec[1];
  assign bus.done       = state_vec[2];
  assign bus.match      = match_q;
  assign bus.diff_count = diff_q;
  assign bus.first_diff = first_q;
  assign bus.bit_idx    = idx_q;
endmodule
